// File: rtl/wisc_pkg.sv
// Shared widths, ALU opcodes and the ID/EX control bundle for the 16-bit WISC pipeline.
package wisc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ROL = 3'b000;
    localparam logic [OP_W-1:0] ALU_SLL = 3'b001;
    localparam logic [OP_W-1:0] ALU_ROR = 3'b010;
    localparam logic [OP_W-1:0] ALU_SRL = 3'b011;
    localparam logic [OP_W-1:0] ALU_ADD = 3'b100;
    localparam logic [OP_W-1:0] ALU_AND = 3'b101;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b110;
    localparam logic [OP_W-1:0] ALU_XOR = 3'b111;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             inva;
        logic             invb;
        logic             cin;
        logic             sign;
        logic             wr_en;
        logic [REG_W-1:0] wr_idx;
        logic             mem_rd;
    } idex_ctrl_t;

    function automatic logic wr_match(input logic en,
                                      input logic [REG_W-1:0] wr_idx,
                                      input logic [REG_W-1:0] rd_idx);
        return en && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/idex_operand_stage_fwd_mux.sv
// Per-operand bypass selector: stored value vs. EX/MEM and MEM/WB results, plus hazard flag.
// IDEX_FORWARD_EN selects forwarding; undefined, any younger-stage match is reported as a hazard.
module fwd_mux
    import wisc_pkg::*;
#(
    parameter int unsigned N = DATA_W,
    parameter int unsigned R = REG_W
) (
    input  logic [N-1:0] stored,
    input  logic [R-1:0] idx,
    input  logic         used,
    input  logic         exm_wr_en,
    input  logic [R-1:0] exm_wr_idx,
    input  logic [N-1:0] exm_data,
    input  logic         exm_is_load,
    input  logic         mwb_wr_en,
    input  logic [R-1:0] mwb_wr_idx,
    input  logic [N-1:0] mwb_data,
    output logic [N-1:0] value,
    output logic         hazard
);

    logic exm_match;
    logic mwb_match;

    assign exm_match = used && wr_match(exm_wr_en, exm_wr_idx, idx);
    assign mwb_match = used && wr_match(mwb_wr_en, mwb_wr_idx, idx);

`ifdef IDEX_FORWARD_EN
    always_comb begin
        value  = stored;
        hazard = exm_match && exm_is_load;
        if (exm_match && !exm_is_load) begin
            value = exm_data;
        end else if (mwb_match) begin
            value = mwb_data;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{exm_data, exm_is_load, mwb_data};

    always_comb begin
        value  = stored;
        hazard = exm_match || mwb_match;
    end
`endif

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX operand stage feeding the ALU: latches decode, forwards/refreshes operands, stalls on hazards.
// Build option IDEX_FORWARD_EN enables EX/MEM and MEM/WB forwarding in fwd_mux.
module idex_operand_stage
    import wisc_pkg::*;
#(
    parameter int unsigned N = DATA_W,
    parameter int unsigned R = REG_W,
    parameter int unsigned O = OP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    output logic         id_ready,
    input  logic [N-1:0] id_rs_data,
    input  logic [N-1:0] id_rt_data,
    input  logic [R-1:0] id_rs_idx,
    input  logic [R-1:0] id_rt_idx,
    input  logic         id_rs_used,
    input  logic         id_rt_used,
    input  logic [N-1:0] id_imm,
    input  logic         id_use_imm,
    input  logic [O-1:0] id_op,
    input  logic         id_inva,
    input  logic         id_invb,
    input  logic         id_cin,
    input  logic         id_sign,
    input  logic         id_wr_en,
    input  logic [R-1:0] id_wr_idx,
    input  logic         id_mem_rd,
    input  logic         flush,
    input  logic         exm_wr_en,
    input  logic [R-1:0] exm_wr_idx,
    input  logic [N-1:0] exm_data,
    input  logic         exm_is_load,
    input  logic         mwb_wr_en,
    input  logic [R-1:0] mwb_wr_idx,
    input  logic [N-1:0] mwb_data,
    input  logic         ex_ready,
    output logic         ex_valid,
    output logic [N-1:0] ex_ina,
    output logic [N-1:0] ex_inb,
    output logic [O-1:0] ex_op,
    output logic         ex_inva,
    output logic         ex_invb,
    output logic         ex_cin,
    output logic         ex_sign,
    output logic         ex_wr_en,
    output logic [R-1:0] ex_wr_idx,
    output logic         ex_mem_rd,
    output logic         ex_hazard
);

    logic         held_valid;
    idex_ctrl_t   ctrl;
    logic [N-1:0] rs_data;
    logic [N-1:0] rt_data;
    logic [N-1:0] imm;
    logic [R-1:0] rs_idx;
    logic [R-1:0] rt_idx;
    logic         rs_used;
    logic         rt_used;
    logic         use_imm;

    logic         fire;
    logic         accept;
    logic         rt_live;
    logic [N-1:0] rs_val;
    logic [N-1:0] rt_val;
    logic         rs_hz;
    logic         rt_hz;

    assign fire     = ex_valid && ex_ready;
    assign id_ready = !held_valid || fire;
    assign accept   = id_valid && id_ready && !flush;

    // An immediate replaces rt, so rt must not stall or be forwarded.
    assign rt_live = rt_used && !use_imm;

    fwd_mux #(.N(N), .R(R)) u_fwd_rs (
        .stored      (rs_data),
        .idx         (rs_idx),
        .used        (rs_used),
        .exm_wr_en   (exm_wr_en),
        .exm_wr_idx  (exm_wr_idx),
        .exm_data    (exm_data),
        .exm_is_load (exm_is_load),
        .mwb_wr_en   (mwb_wr_en),
        .mwb_wr_idx  (mwb_wr_idx),
        .mwb_data    (mwb_data),
        .value       (rs_val),
        .hazard      (rs_hz)
    );

    fwd_mux #(.N(N), .R(R)) u_fwd_rt (
        .stored      (rt_data),
        .idx         (rt_idx),
        .used        (rt_live),
        .exm_wr_en   (exm_wr_en),
        .exm_wr_idx  (exm_wr_idx),
        .exm_data    (exm_data),
        .exm_is_load (exm_is_load),
        .mwb_wr_en   (mwb_wr_en),
        .mwb_wr_idx  (mwb_wr_idx),
        .mwb_data    (mwb_data),
        .value       (rt_val),
        .hazard      (rt_hz)
    );

    assign ex_hazard = held_valid && (rs_hz || rt_hz);
    assign ex_valid  = held_valid && !ex_hazard;
    assign ex_ina    = rs_val;
    assign ex_inb    = use_imm ? imm : rt_val;
    assign ex_op     = ctrl.op;
    assign ex_inva   = ctrl.inva;
    assign ex_invb   = ctrl.invb;
    assign ex_cin    = ctrl.cin;
    assign ex_sign   = ctrl.sign;
    assign ex_wr_en  = ctrl.wr_en;
    assign ex_wr_idx = ctrl.wr_idx;
    assign ex_mem_rd = ctrl.mem_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            ctrl       <= '0;
            rs_data    <= '0;
            rt_data    <= '0;
            imm        <= '0;
            rs_idx     <= '0;
            rt_idx     <= '0;
            rs_used    <= 1'b0;
            rt_used    <= 1'b0;
            use_imm    <= 1'b0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid  <= 1'b1;
            ctrl.op     <= id_op;
            ctrl.inva   <= id_inva;
            ctrl.invb   <= id_invb;
            ctrl.cin    <= id_cin;
            ctrl.sign   <= id_sign;
            ctrl.wr_en  <= id_wr_en;
            ctrl.wr_idx <= id_wr_idx;
            ctrl.mem_rd <= id_mem_rd;
            // The register file is read this cycle, before the concurrent writeback lands.
            rs_data <= wr_match(mwb_wr_en, mwb_wr_idx, id_rs_idx) ? mwb_data : id_rs_data;
            rt_data <= wr_match(mwb_wr_en, mwb_wr_idx, id_rt_idx) ? mwb_data : id_rt_data;
            imm     <= id_imm;
            rs_idx  <= id_rs_idx;
            rt_idx  <= id_rt_idx;
            rs_used <= id_rs_used;
            rt_used <= id_rt_used;
            use_imm <= id_use_imm;
        end else if (fire) begin
            held_valid <= 1'b0;
        end else if (held_valid) begin
            // A writeback retiring during a stall would otherwise be lost.
            if (wr_match(mwb_wr_en, mwb_wr_idx, rs_idx)) begin
                rs_data <= mwb_data;
            end
            if (wr_match(mwb_wr_en, mwb_wr_idx, rt_idx)) begin
                rt_data <= mwb_data;
            end
        end
    end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed self-checking bench for idex_operand_stage; expectations follow IDEX_FORWARD_EN.
module tb_idex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]  id_rs_idx, id_rt_idx, id_wr_idx, id_op;
    logic        id_rs_used, id_rt_used, id_use_imm;
    logic        id_inva, id_invb, id_cin, id_sign, id_wr_en, id_mem_rd;
    logic        flush;
    logic        exm_wr_en, exm_is_load;
    logic [2:0]  exm_wr_idx;
    logic [15:0] exm_data;
    logic        mwb_wr_en;
    logic [2:0]  mwb_wr_idx;
    logic [15:0] mwb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] ex_ina, ex_inb;
    logic [2:0]  ex_op, ex_wr_idx;
    logic        ex_inva, ex_invb, ex_cin, ex_sign, ex_wr_en, ex_mem_rd, ex_hazard;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    always #5 clk = ~clk;

    idex_operand_stage #(.N(16), .R(3), .O(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_op(id_op),
        .id_inva(id_inva), .id_invb(id_invb), .id_cin(id_cin), .id_sign(id_sign),
        .id_wr_en(id_wr_en), .id_wr_idx(id_wr_idx), .id_mem_rd(id_mem_rd),
        .flush(flush),
        .exm_wr_en(exm_wr_en), .exm_wr_idx(exm_wr_idx), .exm_data(exm_data),
        .exm_is_load(exm_is_load),
        .mwb_wr_en(mwb_wr_en), .mwb_wr_idx(mwb_wr_idx), .mwb_data(mwb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ina(ex_ina), .ex_inb(ex_inb),
        .ex_op(ex_op), .ex_inva(ex_inva), .ex_invb(ex_invb), .ex_cin(ex_cin),
        .ex_sign(ex_sign), .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx),
        .ex_mem_rd(ex_mem_rd), .ex_hazard(ex_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] rsi, input logic [15:0] rsd,
                           input logic [2:0] rti, input logic [15:0] rtd,
                           input logic [2:0] op, input logic [2:0] wri);
        id_valid   = 1'b1;
        id_rs_idx  = rsi;  id_rs_data = rsd; id_rs_used = 1'b1;
        id_rt_idx  = rti;  id_rt_data = rtd; id_rt_used = 1'b1;
        id_op      = op;   id_wr_en   = 1'b1; id_wr_idx = wri;
        id_use_imm = 1'b0; id_imm     = 16'h0000;
    endtask

    task automatic quiet_wb();
        exm_wr_en = 1'b0; exm_wr_idx = 3'd0; exm_data = 16'h0; exm_is_load = 1'b0;
        mwb_wr_en = 1'b0; mwb_wr_idx = 3'd0; mwb_data = 16'h0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_rs_idx = '0; id_rt_idx = '0;
        id_wr_idx = '0; id_op = '0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_use_imm = 1'b0;
        id_inva = 1'b0; id_invb = 1'b0; id_cin = 1'b0; id_sign = 1'b0; id_wr_en = 1'b0;
        id_mem_rd = 1'b0;
        quiet_wb();
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_ina", ex_ina, 16'h0);
        chk("rst_inb", ex_inb, 16'h0);
        chk("rst_op", ex_op, 0);
        chk("rst_wr_en", ex_wr_en, 0);
        chk("rst_hazard", ex_hazard, 0);
        chk("rst_ready", id_ready, 1);

        // 1: plain accept, one-cycle latency
        present(3'd1, 16'h1234, 3'd2, 16'h0001, 3'b100, 3'd4);
        step();
        id_valid = 1'b0;
        chk("t1_valid", ex_valid, 1);
        chk("t1_ina", ex_ina, 16'h1234);
        chk("t1_inb", ex_inb, 16'h0001);
        chk("t1_op", ex_op, 3'b100);
        chk("t1_wr_idx", ex_wr_idx, 3'd4);
        chk("t1_ready", id_ready, 1);
        step();
        chk("t1_drain", ex_valid, 0);

        // 2: EX/MEM and MEM/WB both match rs
        ex_ready = 1'b0;
        present(3'd3, 16'h0003, 3'd5, 16'h0007, 3'b111, 3'd6);
        step();
        id_valid = 1'b0;
        exm_wr_en = 1'b1; exm_wr_idx = 3'd3; exm_data = 16'hBEEF;
        mwb_wr_en = 1'b1; mwb_wr_idx = 3'd3; mwb_data = 16'h1111;
        #1;
`ifdef IDEX_FORWARD_EN
        chk("t2_ina", ex_ina, 16'hBEEF);
        chk("t2_valid", ex_valid, 1);
        exm_wr_en = 1'b0;
        #1;
        chk("t2_mwb_ina", ex_ina, 16'h1111);
`else
        chk("t2_ina", ex_ina, 16'h0003);
        chk("t2_hazard", ex_hazard, 1);
        chk("t2_valid", ex_valid, 0);
`endif
        quiet_wb();
        ex_ready = 1'b1;
        #1;
        chk("t2_clear_ina", ex_ina, 16'h0003);
        chk("t2_clear_valid", ex_valid, 1);
        step();

        // 3: load-use on rt
        present(3'd1, 16'h0010, 3'd6, 16'h0020, 3'b100, 3'd2);
        step();
        id_valid = 1'b0;
        exm_wr_en = 1'b1; exm_wr_idx = 3'd6; exm_data = 16'hDEAD; exm_is_load = 1'b1;
        #1;
        chk("t3_valid", ex_valid, 0);
        chk("t3_hazard", ex_hazard, 1);
        chk("t3_ready", id_ready, 0);
        step();
        quiet_wb();
        mwb_wr_en = 1'b1; mwb_wr_idx = 3'd6; mwb_data = 16'h00AA;
        #1;
`ifdef IDEX_FORWARD_EN
        chk("t3_fwd_valid", ex_valid, 1);
        chk("t3_fwd_inb", ex_inb, 16'h00AA);
        step();
        quiet_wb();
`else
        chk("t3_mwb_hazard", ex_hazard, 1);
        step();
        quiet_wb();
        #1;
        chk("t3_ref_valid", ex_valid, 1);
        chk("t3_ref_inb", ex_inb, 16'h00AA);
        step();
`endif
        chk("t3_drain", ex_valid, 0);

        // 4: backpressure with a writeback during the stall
        ex_ready = 1'b0;
        present(3'd2, 16'h0002, 3'd3, 16'h0003, 3'b101, 3'd1);
        step();
        id_valid = 1'b0;
        chk("t4_c1_ready", id_ready, 0);
        chk("t4_c1_valid", ex_valid, 1);
        step();
        mwb_wr_en = 1'b1; mwb_wr_idx = 3'd2; mwb_data = 16'h5555;
        #1;
        chk("t4_c2_ready", id_ready, 0);
        step();
        quiet_wb();
        #1;
        chk("t4_c3_ina", ex_ina, 16'h5555);
        chk("t4_c3_ready", id_ready, 0);
        ex_ready = 1'b1;
        #1;
        chk("t4_rel_valid", ex_valid, 1);
        chk("t4_rel_ina", ex_ina, 16'h5555);
        chk("t4_rel_ready", id_ready, 1);
        step();

        // 5: flush with a simultaneous new instruction
        ex_ready = 1'b0;
        present(3'd1, 16'h0A0A, 3'd2, 16'h0B0B, 3'b111, 3'd3);
        step();
        present(3'd4, 16'hCCCC, 3'd5, 16'hDDDD, 3'b001, 3'd7);
        flush = 1'b1;
        step();
        flush = 1'b0; id_valid = 1'b0;
        chk("t5_valid", ex_valid, 0);
        chk("t5_ready", id_ready, 1);
        chk("t5_op_kept", ex_op, 3'b111);
        chk("t5_ina_kept", ex_ina, 16'h0A0A);

        // decode bypass: writeback to rs index in the accept cycle
        ex_ready = 1'b1;
        present(3'd4, 16'h9999, 3'd5, 16'h0005, 3'b100, 3'd0);
        mwb_wr_en = 1'b1; mwb_wr_idx = 3'd4; mwb_data = 16'h4444;
        step();
        id_valid = 1'b0;
        quiet_wb();
        #1;
        chk("byp_ina", ex_ina, 16'h4444);
        chk("byp_inb", ex_inb, 16'h0005);
        step();

        // 6: reset mid-stall, then immediate ignores rt load hazard
        ex_ready = 1'b0;
        present(3'd3, 16'h7777, 3'd1, 16'h8888, 3'b110, 3'd5);
        step();
        id_valid = 1'b0;
        chk("t6_pre_valid", ex_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_valid", ex_valid, 0);
        chk("t6_ina", ex_ina, 16'h0);
        chk("t6_inb", ex_inb, 16'h0);
        chk("t6_op", ex_op, 0);
        chk("t6_wr_en", ex_wr_en, 0);
        chk("t6_ready", id_ready, 1);
        ex_ready = 1'b1;
        present(3'd1, 16'h0100, 3'd7, 16'h0FFF, 3'b100, 3'd2);
        id_use_imm = 1'b1; id_imm = 16'h0042;
        step();
        id_valid = 1'b0; id_use_imm = 1'b0;
        exm_wr_en = 1'b1; exm_wr_idx = 3'd7; exm_data = 16'hDEAD; exm_is_load = 1'b1;
        #1;
        chk("t6_imm_hazard", ex_hazard, 0);
        chk("t6_imm_valid", ex_valid, 1);
        chk("t6_imm_inb", ex_inb, 16'h0042);
        chk("t6_imm_ina", ex_ina, 16'h0100);
        step();
        quiet_wb();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
